// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, performs reset/NMI/IRQ vector fetch,
// single-cycle increment, two-step absolute load and 6502-style relative branch.
module pc_sequencer #(
   parameter int              ADDR_W  = 16,
   parameter int              DATA_W  = 8,
   parameter int              PAGE_W  = 8,
   parameter logic [ADDR_W-1:0] VEC_NMI = 'hFFFA,
   parameter logic [ADDR_W-1:0] VEC_RST = 'hFFFC,
   parameter logic [ADDR_W-1:0] VEC_IRQ = 'hFFFE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              busy,
   output logic              page_cross
);
   localparam int HI_W = ADDR_W - PAGE_W;

   typedef enum logic [1:0] {VEC_L, VEC_H, IDLE, BR_FIX} state_t;

   localparam logic [2:0] OP_INC    = 3'd1;
   localparam logic [2:0] OP_LOAD_L = 3'd2;
   localparam logic [2:0] OP_LOAD_H = 3'd3;
   localparam logic [2:0] OP_BRANCH = 3'd4;
   localparam logic [2:0] OP_VECTOR = 3'd5;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
   logic [DATA_W-1:0] temp_q, temp_d;
   logic              dir_q, dir_d;
   logic              cmd_ready_q, busy_q, page_cross_q;

   logic [PAGE_W-1:0] off_lo;
   logic [PAGE_W:0]   low_sum;
   logic              off_neg, crossed;
   logic [HI_W-1:0]   pc_hi;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      vec_addr_d = vec_addr_q;
      temp_d     = temp_q;
      dir_d      = dir_q;
      bus_addr   = pc_q;
      pc_hi      = pc_q[ADDR_W-1:PAGE_W];

      // Low-page add; a borrow for a negative offset shows up as a missing carry.
      off_lo  = PAGE_W'($signed(cmd_data));
      off_neg = cmd_data[DATA_W-1];
      low_sum = {1'b0, pc_q[PAGE_W-1:0]} + {1'b0, off_lo};
      crossed = off_neg ? ~low_sum[PAGE_W] : low_sum[PAGE_W];

      case (state_q)
         VEC_L: begin
            bus_addr = vec_addr_q;
            temp_d   = data_in;
            state_d  = VEC_H;
         end
         VEC_H: begin
            bus_addr = vec_addr_q + ADDR_W'(1);
            pc_d     = ADDR_W'({data_in, temp_q});
            state_d  = IDLE;
         end
         BR_FIX: begin
            pc_d    = {(dir_q ? pc_hi - HI_W'(1) : pc_hi + HI_W'(1)), pc_q[PAGE_W-1:0]};
            state_d = IDLE;
         end
         default: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_INC:    pc_d = pc_q + ADDR_W'(1);
                  OP_LOAD_L: temp_d = cmd_data;
                  OP_LOAD_H: pc_d = ADDR_W'({cmd_data, temp_q});
                  OP_BRANCH: begin
                     pc_d = {pc_hi, low_sum[PAGE_W-1:0]};
                     if (crossed) begin
                        dir_d   = off_neg;
                        state_d = BR_FIX;
                     end
                  end
                  OP_VECTOR: begin
                     case (cmd_data[1:0])
                        2'd0:    vec_addr_d = VEC_NMI;
                        2'd2:    vec_addr_d = VEC_IRQ;
                        default: vec_addr_d = VEC_RST;
                     endcase
                     state_d = VEC_L;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= VEC_L;
         pc_q         <= '0;
         vec_addr_q   <= VEC_RST;
         temp_q       <= '0;
         dir_q        <= 1'b0;
         cmd_ready_q  <= 1'b0;
         busy_q       <= 1'b1;
         page_cross_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         vec_addr_q   <= vec_addr_d;
         temp_q       <= temp_d;
         dir_q        <= dir_d;
         cmd_ready_q  <= (state_d == IDLE);
         busy_q       <= (state_d != IDLE);
         page_cross_q <= (state_d == BR_FIX);
      end
   end

   assign pc         = pc_q;
   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign page_cross = page_cross_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios, then randomized commands checked
// against a cycle-sequence reference model built from branch/load/vector rules.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic [7:0]  data_in;
   logic [15:0] pc;
   logic [15:0] bus_addr;
   logic        busy;
   logic        page_cross;

   logic [7:0]  vmem [0:5];
   int          n_chk = 0;
   int          n_pass = 0;

   typedef struct {
      logic [15:0] pc;
      logic        rdy;
      logic        pcx;
      logic [15:0] ba;
   } snap_t;

   snap_t       q[$];
   logic [15:0] mpc;
   logic [7:0]  mtemp;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .data_in(data_in), .pc(pc),
      .bus_addr(bus_addr), .busy(busy), .page_cross(page_cross)
   );

   always #5 clk = ~clk;

   always_comb begin
      data_in = bus_addr[7:0] ^ 8'hA5;
      if (bus_addr >= 16'hFFFA) data_in = vmem[int'(bus_addr) - 32'hFFFA];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] d);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      tick();
      cmd_valid = 1'b0; cmd_op = 3'd0;
   endtask

   task automatic load(input logic [15:0] a);
      issue(3'd2, a[7:0]);
      issue(3'd3, a[15:8]);
   endtask

   function automatic snap_t idle(input logic [15:0] p);
      snap_t s;
      s.pc = p; s.rdy = 1'b1; s.pcx = 1'b0; s.ba = p;
      return s;
   endfunction

   function automatic snap_t wait_s(input logic [15:0] p, input logic pcx, input logic [15:0] ba);
      snap_t s;
      s.pc = p; s.rdy = 1'b0; s.pcx = pcx; s.ba = ba;
      return s;
   endfunction

   // Observable sequence following an accepted command, from the instruction semantics.
   task automatic model(input logic [2:0] op, input logic [7:0] d);
      logic [15:0] tgt, mid, va;
      case (op)
         3'd1: q.push_back(idle(mpc + 16'd1));
         3'd2: begin mtemp = d; q.push_back(idle(mpc)); end
         3'd3: q.push_back(idle({d, mtemp}));
         3'd4: begin
            tgt = mpc + {{8{d[7]}}, d};
            if (tgt[15:8] != mpc[15:8]) begin
               mid = {mpc[15:8], tgt[7:0]};
               q.push_back(wait_s(mid, 1'b1, mid));
               q.push_back(idle(tgt));
            end else q.push_back(idle(tgt));
         end
         3'd5: begin
            va = (d[1:0] == 2'd0) ? 16'hFFFA : (d[1:0] == 2'd2) ? 16'hFFFE : 16'hFFFC;
            q.push_back(wait_s(mpc, 1'b0, va));
            q.push_back(wait_s(mpc, 1'b0, va + 16'd1));
            mtemp = vmem[int'(va) - 32'hFFFA];
            q.push_back(idle({vmem[int'(va) - 32'hFFF9], mtemp}));
         end
         default: q.push_back(idle(mpc));
      endcase
   endtask

   initial begin
      snap_t       s;
      logic [2:0]  rop;
      logic [7:0]  rd;
      logic        rv;

      vmem[0] = 8'h00; vmem[1] = 8'hC0;
      vmem[2] = 8'h34; vmem[3] = 8'h12;
      vmem[4] = 8'h78; vmem[5] = 8'h56;
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;

      #12;
      chk("rst_pc", 32'(pc), 32'h0000);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_pcx", 32'(page_cross), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_bus", 32'(bus_addr), 32'hFFFC);

      tick();
      rst = 1'b1;
      chk("vec_l_bus", 32'(bus_addr), 32'hFFFC);
      tick();
      chk("vec_h_bus", 32'(bus_addr), 32'hFFFD);
      chk("vec_h_ready", 32'(cmd_ready), 32'd0);
      tick();
      chk("vec_pc", 32'(pc), 32'h1234);
      chk("vec_ready", 32'(cmd_ready), 32'd1);
      chk("vec_busy", 32'(busy), 32'd0);

      load(16'hFFFF);
      issue(3'd1, 8'h00);
      chk("inc_wrap", 32'(pc), 32'h0000);
      chk("inc_busy", 32'(busy), 32'd0);

      load(16'h1234);
      issue(3'd4, 8'h10);
      chk("br_fwd_pc", 32'(pc), 32'h1244);
      chk("br_fwd_pcx", 32'(page_cross), 32'd0);
      chk("br_fwd_ready", 32'(cmd_ready), 32'd1);

      load(16'h12F0);
      issue(3'd4, 8'h20);
      chk("brx_mid_pc", 32'(pc), 32'h1210);
      chk("brx_mid_pcx", 32'(page_cross), 32'd1);
      chk("brx_mid_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1; cmd_op = 3'd1;
      tick();
      cmd_valid = 1'b0; cmd_op = 3'd0;
      chk("brx_fix_pc", 32'(pc), 32'h1310);
      chk("brx_fix_pcx", 32'(page_cross), 32'd0);
      tick();
      chk("brx_inc_ignored", 32'(pc), 32'h1310);

      load(16'h1205);
      issue(3'd4, 8'hF0);
      chk("brb_mid_pc", 32'(pc), 32'h12F5);
      chk("brb_mid_pcx", 32'(page_cross), 32'd1);
      tick();
      chk("brb_fix_pc", 32'(pc), 32'h11F5);
      issue(3'd2, 8'hCD);
      chk("loadl_hold", 32'(pc), 32'h11F5);
      issue(3'd3, 8'hAB);
      chk("loadh_pc", 32'(pc), 32'hABCD);

      load(16'h12F0);
      issue(3'd4, 8'h20);
      rst = 1'b0;
      #1;
      chk("abort_pc", 32'(pc), 32'h0000);
      chk("abort_bus", 32'(bus_addr), 32'hFFFC);
      chk("abort_pcx", 32'(page_cross), 32'd0);
      #1 rst = 1'b1;
      tick();
      tick();
      chk("abort_refetch", 32'(pc), 32'h1234);

      issue(3'd5, 8'h00);
      chk("nmi_bus_l", 32'(bus_addr), 32'hFFFA);
      chk("nmi_busy", 32'(busy), 32'd1);
      tick();
      chk("nmi_bus_h", 32'(bus_addr), 32'hFFFB);
      tick();
      chk("nmi_pc", 32'(pc), 32'hC000);

      mpc = 16'hC000; mtemp = 8'h00;
      vmem[0] = 8'($urandom); vmem[1] = 8'($urandom);
      vmem[4] = 8'($urandom); vmem[5] = 8'($urandom);
      for (int i = 0; i < 400; i++) begin
         rop = 3'($urandom_range(0, 7));
         rd  = 8'($urandom);
         rv  = ($urandom_range(0, 3) != 0);
         cmd_valid = rv; cmd_op = rop; cmd_data = rd;
         if (q.size() == 0) begin
            if (rv) model(rop, rd);
            else q.push_back(idle(mpc));
         end
         tick();
         s = q.pop_front();
         mpc = s.pc;
         chk("rnd_pc", 32'(pc), 32'(s.pc));
         chk("rnd_ready", 32'(cmd_ready), 32'(s.rdy));
         chk("rnd_busy", 32'(busy), 32'(!s.rdy));
         chk("rnd_pcx", 32'(page_cross), 32'(s.pcx));
         chk("rnd_bus", 32'(bus_addr), 32'(s.ba));
      end
      cmd_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
